psr_interrupt_sequencer: RTL and testbench

- Sequences the 6502 interrupt, BRK and reset entry cycles for the CPU core.
- Arbitrates between the reset, NMI, BRK and IRQ requesters.
- Drives the stack-push strobes and the process status register control lines: break_set during the P push, manual_set/manual_I/man_I to set the I flag.
- Produces the vector address for the two vector fetches. Sits between the instruction decoder/RCL and the status register wrapper and stack/address datapath.

---
 rtl/psr_interrupt_sequencer_if.sv | 36 +++
 rtl/psr_interrupt_sequencer.sv | 154 +++++++++++++++
 tb/tb_psr_interrupt_sequencer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/psr_interrupt_sequencer_if.sv
// Signal bundle between the decoder/PSR/stack datapath and the interrupt sequencer.
// The master side drives requests and handshakes; the sequencer is the slave.
interface psr_interrupt_sequencer_if;
  logic        ready;
  logic        instr_done;
  logic        brk_decode;
  logic        irq;
  logic        nmi;
  logic        psr_i;

  logic        busy;
  logic        stack_cycle;
  logic        stack_wr;
  logic [1:0]  stack_sel;
  logic        break_set;
  logic        manual_set;
  logic        manual_I;
  logic        man_I;
  logic        vec_fetch;
  logic        vec_hi;
  logic [15:0] vector_addr;
  logic        seq_done;
  logic [1:0]  src;

  modport master (
    output ready, instr_done, brk_decode, irq, nmi, psr_i,
    input  busy, stack_cycle, stack_wr, stack_sel, break_set, manual_set, manual_I, man_I,
    input  vec_fetch, vec_hi, vector_addr, seq_done, src
  );

  modport slave (
    input  ready, instr_done, brk_decode, irq, nmi, psr_i,
    output busy, stack_cycle, stack_wr, stack_sel, break_set, manual_set, manual_I, man_I,
    output vec_fetch, vec_hi, vector_addr, seq_done, src
  );
endinterface

// File: rtl/psr_interrupt_sequencer.sv
// 6502 reset/NMI/BRK/IRQ entry sequencer: three stack pushes, then two vector fetches,
// with NMI hijack of BRK/IRQ during the PC pushes and ready-based stalling.
module psr_interrupt_sequencer #(
  parameter logic [15:0] NMI_VEC = 16'hFFFA,
  parameter logic [15:0] RST_VEC = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
  input logic                      clk,
  input logic                      rst,
  psr_interrupt_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StPushPch, StPushPcl, StPushP, StVecLo, StVecHi
  } state_e;

  typedef enum logic [1:0] {
    SrcRst = 2'b00, SrcNmi = 2'b01, SrcBrk = 2'b10, SrcIrq = 2'b11
  } src_e;

  state_e state_q, state_d;
  src_e   src_q, src_d;
  logic   brk_q, brk_d;
  logic   rst_pending_q, rst_pending_d;
  logic   nmi_pending_q, nmi_pending_d;
  logic   nmi_prev_q;

  logic   nmi_edge, nmi_now;
  logic [15:0] vec_base;

  assign nmi_edge = bus.nmi & ~nmi_prev_q;
  // An edge seen this cycle counts as pending immediately, so it can win arbitration.
  assign nmi_now  = nmi_pending_q | nmi_edge;

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    brk_d         = brk_q;
    rst_pending_d = rst_pending_q;
    nmi_pending_d = nmi_now;
    if (bus.ready) begin
      unique case (state_q)
        StIdle: begin
          if (rst_pending_q) begin
            state_d = StPushPch;
            src_d   = SrcRst;
            brk_d   = 1'b0;
          end else if (bus.instr_done) begin
            if (nmi_now) begin
              state_d = StPushPch;
              src_d   = SrcNmi;
              brk_d   = 1'b0;
            end else if (bus.brk_decode) begin
              state_d = StPushPch;
              src_d   = SrcBrk;
              brk_d   = 1'b1;
            end else if (bus.irq && !bus.psr_i) begin
              state_d = StPushPch;
              src_d   = SrcIrq;
              brk_d   = 1'b0;
            end
          end
        end
        StPushPch: state_d = StPushPcl;
        StPushPcl: begin
          state_d = StPushP;
          // Hijack: the P push and vectors go to NMI, B keeps its BRK value.
          if ((src_q == SrcBrk || src_q == SrcIrq) && nmi_now) src_d = SrcNmi;
        end
        StPushP: begin
          state_d = StVecLo;
          if (src_q == SrcRst) rst_pending_d = 1'b0;
          // A fresh edge in this cycle survives the clear and is serviced later.
          if (src_q == SrcNmi) nmi_pending_d = nmi_edge;
        end
        StVecLo: state_d = StVecHi;
        StVecHi: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      src_q         <= SrcRst;
      brk_q         <= 1'b0;
      rst_pending_q <= 1'b1;
      nmi_pending_q <= 1'b0;
      nmi_prev_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      brk_q         <= brk_d;
      rst_pending_q <= rst_pending_d;
      nmi_pending_q <= nmi_pending_d;
      nmi_prev_q    <= bus.nmi;
    end
  end

  always_comb begin
    unique case (src_q)
      SrcRst:  vec_base = RST_VEC;
      SrcNmi:  vec_base = NMI_VEC;
      default: vec_base = IRQ_VEC;
    endcase
  end

  always_comb begin
    bus.busy        = 1'b0;
    bus.stack_cycle = 1'b0;
    bus.stack_wr    = 1'b0;
    bus.stack_sel   = 2'b00;
    bus.break_set   = 1'b0;
    bus.manual_set  = 1'b0;
    bus.manual_I    = 1'b0;
    bus.man_I       = 1'b0;
    bus.vec_fetch   = 1'b0;
    bus.vec_hi      = 1'b0;
    bus.vector_addr = vec_base;
    bus.seq_done    = 1'b0;
    bus.src         = src_q;
    unique case (state_q)
      StIdle: ;
      StPushPch, StPushPcl, StPushP: begin
        bus.busy        = 1'b1;
        bus.stack_cycle = 1'b1;
        // Reset entry runs the push cycles as dummies.
        bus.stack_wr    = (src_q != SrcRst);
        if (state_q == StPushPcl) bus.stack_sel = 2'b01;
        if (state_q == StPushP) begin
          bus.stack_sel = 2'b10;
          bus.break_set = brk_q;
        end
      end
      StVecLo: begin
        bus.busy       = 1'b1;
        bus.vec_fetch  = 1'b1;
        bus.manual_set = 1'b1;
        bus.manual_I   = 1'b1;
        bus.man_I      = 1'b1;
      end
      StVecHi: begin
        bus.busy        = 1'b1;
        bus.vec_fetch   = 1'b1;
        bus.vec_hi      = 1'b1;
        bus.vector_addr = vec_base + 16'd1;
        bus.seq_done    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_psr_interrupt_sequencer.sv
// Directed bench for psr_interrupt_sequencer with a per-cycle expected-output scoreboard.
module tb_psr_interrupt_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  psr_interrupt_sequencer_if bus ();

  psr_interrupt_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {busy, stack_cycle, stack_wr, stack_sel, break_set, manual_set, manual_I, man_I,
  //  vec_fetch, vec_hi, seq_done, src, vector_addr}
  logic [29:0] obs;
  assign obs = {bus.busy, bus.stack_cycle, bus.stack_wr, bus.stack_sel, bus.break_set,
                bus.manual_set, bus.manual_I, bus.man_I, bus.vec_fetch, bus.vec_hi,
                bus.seq_done, bus.src, bus.vector_addr};

  localparam logic [1:0] RST = 2'b00, NMI = 2'b01, BRK = 2'b10, IRQ = 2'b11;

  int n_pass  = 0;
  int n_total = 0;
  logic [29:0] exp_q[$];

  // st: 0 idle, 1 PCH, 2 PCL, 3 P, 4 VEC_LO, 5 VEC_HI
  function automatic logic [29:0] mk(input int st, input logic [1:0] s, input logic brk);
    logic [15:0] base;
    logic [29:0] r;
    base = (s == RST) ? 16'hFFFC : (s == NMI) ? 16'hFFFA : 16'hFFFE;
    r = '0;
    r[17:16] = s;
    r[15:0]  = base;
    case (st)
      1, 2, 3: begin
        r[29]    = 1'b1;
        r[28]    = 1'b1;
        r[27]    = (s != RST);
        r[26:25] = 2'(st - 1);
        r[24]    = (st == 3) && brk;
      end
      4: begin
        r[29]    = 1'b1;
        r[23:20] = 4'b1111;
      end
      5: begin
        r[29]   = 1'b1;
        r[20]   = 1'b1;
        r[19]   = 1'b1;
        r[18]   = 1'b1;
        r[15:0] = base + 16'd1;
      end
      default: ;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [29:0] o, input logic [29:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, o, e);
  endtask

  task automatic push_seq(input logic [1:0] s_early, input logic [1:0] s_late, input logic brk);
    for (int st = 1; st <= 5; st++) exp_q.push_back(mk(st, (st < 3) ? s_early : s_late, brk));
  endtask

  // Wait (bounded) for busy, then compare one expected entry per cycle, then idle.
  task automatic run_seq(input string tag, input logic [1:0] idle_src);
    int n = 0;
    int i = 0;
    while (!obs[29] && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " start"}, {29'd0, obs[29]}, 30'd1);
    while (exp_q.size() > 0) begin
      chk($sformatf("%s c%0d", tag, i), obs, exp_q.pop_front());
      tick();
      i++;
    end
    chk({tag, " idle"}, obs, mk(0, idle_src, 1'b0));
  endtask

  initial begin
    rst = 1'b1;
    bus.ready = 1'b1;
    bus.instr_done = 1'b0;
    bus.brk_decode = 1'b0;
    bus.irq = 1'b0;
    bus.nmi = 1'b0;
    bus.psr_i = 1'b0;

    // Reset held for 3 cycles, then the dummy-push reset sequence.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("reset hold %0d", k), obs, mk(0, RST, 1'b0));
    end
    rst = 1'b0;
    push_seq(RST, RST, 1'b0);
    run_seq("reset seq", RST);

    // BRK
    bus.instr_done = 1'b1;
    bus.brk_decode = 1'b1;
    push_seq(BRK, BRK, 1'b1);
    tick();
    bus.instr_done = 1'b0;
    bus.brk_decode = 1'b0;
    run_seq("brk seq", BRK);

    // IRQ masked by I
    bus.irq = 1'b1;
    bus.psr_i = 1'b1;
    bus.instr_done = 1'b1;
    tick();
    bus.instr_done = 1'b0;
    chk("irq masked", obs, mk(0, BRK, 1'b0));
    tick();
    chk("irq masked 2", obs, mk(0, BRK, 1'b0));

    // IRQ unmasked, irq dropped mid-sequence
    bus.psr_i = 1'b0;
    bus.instr_done = 1'b1;
    push_seq(IRQ, IRQ, 1'b0);
    tick();
    bus.instr_done = 1'b0;
    bus.irq = 1'b0;
    run_seq("irq seq", IRQ);

    // NMI edge beats IRQ at the same instr_done
    bus.irq = 1'b1;
    bus.nmi = 1'b1;
    bus.instr_done = 1'b1;
    push_seq(NMI, NMI, 1'b0);
    tick();
    bus.instr_done = 1'b0;
    bus.irq = 1'b0;
    run_seq("nmi seq", NMI);

    // NMI held high: no new edge, no second sequence
    bus.instr_done = 1'b1;
    tick();
    bus.instr_done = 1'b0;
    chk("nmi level held", obs, mk(0, NMI, 1'b0));
    tick();
    chk("nmi level held 2", obs, mk(0, NMI, 1'b0));

    // Second NMI pulse, serviced at the following instr_done
    bus.nmi = 1'b0;
    tick();
    bus.nmi = 1'b1;
    tick();
    bus.nmi = 1'b0;
    chk("nmi pending waits", obs, mk(0, NMI, 1'b0));
    bus.instr_done = 1'b1;
    push_seq(NMI, NMI, 1'b0);
    tick();
    bus.instr_done = 1'b0;
    run_seq("nmi seq 2", NMI);

    // BRK hijacked by NMI in PUSH_PCH, with a 2-cycle stall in PUSH_PCL
    bus.instr_done = 1'b1;
    bus.brk_decode = 1'b1;
    tick();
    bus.instr_done = 1'b0;
    bus.brk_decode = 1'b0;
    bus.nmi = 1'b1;
    chk("hijack pch", obs, mk(1, BRK, 1'b1));
    tick();
    bus.nmi = 1'b0;
    chk("hijack pcl", obs, mk(2, BRK, 1'b1));
    bus.ready = 1'b0;
    tick();
    chk("stall 1", obs, mk(2, BRK, 1'b1));
    tick();
    chk("stall 2", obs, mk(2, BRK, 1'b1));
    bus.ready = 1'b1;
    tick();
    chk("hijack p", obs, mk(3, NMI, 1'b1));
    tick();
    exp_q.push_back(mk(4, NMI, 1'b0));
    exp_q.push_back(mk(5, NMI, 1'b0));
    run_seq("hijack vec", NMI);

    // Reset asserted during PUSH_P of an IRQ sequence
    bus.irq = 1'b1;
    bus.instr_done = 1'b1;
    tick();
    bus.instr_done = 1'b0;
    bus.irq = 1'b0;
    chk("abort pch", obs, mk(1, IRQ, 1'b0));
    tick();
    chk("abort pcl", obs, mk(2, IRQ, 1'b0));
    tick();
    chk("abort p", obs, mk(3, IRQ, 1'b0));
    rst = 1'b1;
    tick();
    chk("abort idle", obs, mk(0, RST, 1'b0));
    rst = 1'b0;
    push_seq(RST, RST, 1'b0);
    run_seq("reset seq 2", RST);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
